imem_dmem_server: RTL and testbench

Memory-side responder for the multi-cycle MIPS-subset core: it serves the core's instruction-fetch requests (32-bit words) and `lw` byte-load requests (8-bit rows) over a request/grant/response handshake. It also accepts a loader write port so programs and data arrays are written in instead of being hard-coded in `initial` blocks. It sits between the core and its instruction/data storage, with one outstanding request at a time.

---
 rtl/imem_dmem_server.sv | 140 ++++++++++++++
 tb/tb_imem_dmem_server.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_server.sv
// imem_dmem_server: memory-side responder for a multi-cycle MIPS-subset core.
// Serves 32-bit instruction fetches and 8-bit data loads, one outstanding
// request at a time, with a fixed grant-to-response latency. A loader write
// port fills either memory at any time.
// Optional feature macro: ROUND_ROBIN_EN (alternate grants on ties; default
// is fixed priority, load over fetch).
module imem_dmem_server #(
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ld_req,
  input  logic [7:0]  ld_addr,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [7:0]  ld_rdata,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        err
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [7:0]  dmem [DMEM_DEPTH];

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        sel_ld;      // granted port of the in-flight request
  logic        last_ld;     // last granted port, for tie alternation
  logic [31:0] hold;        // data captured at grant
  logic [31:0] if_rdata_q;
  logic [7:0]  ld_rdata_q;

  logic        pick_ld, pick_if, gnt_any;
  logic        if_in, ld_in, wr_in;
  logic [31:0] rd_if, rd_ld;

  // Range checks and memory read mux; out-of-range reads return zero
  always_comb begin
    if_in = int'(if_addr) < IMEM_DEPTH;
    ld_in = int'(ld_addr) < DMEM_DEPTH;
    wr_in = wr_sel ? (int'(wr_addr) < DMEM_DEPTH) : (int'(wr_addr) < IMEM_DEPTH);
    rd_if = if_in ? imem[if_addr[IAW-1:0]] : '0;
    rd_ld = ld_in ? {24'b0, dmem[ld_addr[DAW-1:0]]} : '0;
  end

  // Arbitration between the two request ports, only in IDLE and out of reset
  always_comb begin
`ifdef ROUND_ROBIN_EN
    pick_ld = ld_req && (!if_req || !last_ld);
`else
    pick_ld = ld_req;
`endif
    pick_if = if_req && !pick_ld;
    if (state != IDLE || !rst_n) begin
      pick_ld = 1'b0;
      pick_if = 1'b0;
    end
    gnt_any = pick_ld || pick_if;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (gnt_any) next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; rdata shows the holding register during the response cycle
  always_comb begin
    if_gnt    = pick_if;
    ld_gnt    = pick_ld;
    busy      = (state != IDLE);
    if_rvalid = (state == RESP) && !sel_ld;
    ld_rvalid = (state == RESP) && sel_ld;
    if_rdata  = if_rvalid ? hold : if_rdata_q;
    ld_rdata  = ld_rvalid ? hold[7:0] : ld_rdata_q;
  end

  // Request capture, latency counter, response hold registers and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel_ld     <= 1'b0;
      last_ld    <= 1'b0;
      hold       <= '0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
      err        <= 1'b0;
    end else begin
      if (gnt_any) begin
        hold    <= pick_ld ? rd_ld : rd_if;
        sel_ld  <= pick_ld;
        last_ld <= pick_ld;
        cnt     <= (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
        if ((pick_ld && !ld_in) || (pick_if && !if_in)) err <= 1'b1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) begin
        if (sel_ld) ld_rdata_q <= hold[7:0];
        else        if_rdata_q <= hold;
      end
      if (wr_en && !wr_in) err <= 1'b1;
    end
  end

  // Loader writes; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && wr_in) begin
      if (wr_sel) dmem[wr_addr[DAW-1:0]] <= wr_data[7:0];
      else        imem[wr_addr[IAW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_imem_dmem_server.sv
// Directed testbench for imem_dmem_server (IMEM_DEPTH=DMEM_DEPTH=16, LATENCY=2).
module tb_imem_dmem_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ld_req, wr_en, wr_sel;
  logic [7:0]  if_addr, ld_addr, wr_addr;
  logic [31:0] wr_data;
  logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, busy, err;
  logic [31:0] if_rdata;
  logic [7:0]  ld_rdata;

  int total = 0;
  int bad   = 0;

  imem_dmem_server #(.IMEM_DEPTH(16), .DMEM_DEPTH(16), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    #1 chk({tag, "_gnt"}, {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, {31'b0, if_rvalid}, 32'd1);
    chk({tag, "_rdata"}, if_rdata, exp);
  endtask

  task automatic load(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = a;
    #1 chk({tag, "_gnt"}, {31'b0, ld_gnt}, 32'd1);
    @(negedge clk);
    ld_req = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, {31'b0, ld_rvalid}, 32'd1);
    chk({tag, "_rdata"}, {24'b0, ld_rdata}, {24'b0, exp});
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_if_gnt"},    {31'b0, if_gnt},    32'd0);
    chk({tag, "_ld_gnt"},    {31'b0, ld_gnt},    32'd0);
    chk({tag, "_if_rvalid"}, {31'b0, if_rvalid}, 32'd0);
    chk({tag, "_ld_rvalid"}, {31'b0, ld_rvalid}, 32'd0);
    chk({tag, "_if_rdata"},  if_rdata,           32'd0);
    chk({tag, "_ld_rdata"},  {24'b0, ld_rdata},  32'd0);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
    chk({tag, "_err"},       {31'b0, err},       32'd0);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    if_addr = '0; ld_addr = '0; wr_addr = '0; wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_zero("rst");
    rst_n = 1'b1;

    // Preload memories
    wr(1'b0, 8'd3,  32'h2403000A);
    wr(1'b0, 8'd5,  32'h12345678);
    wr(1'b1, 8'd10, 32'h0000000A);
    wr(1'b1, 8'd2,  32'h00000001);
    wr(1'b1, 8'd0,  32'h00000077);

    // Fetch with full timing: grant T, busy T+1..T+2, rvalid only at T+2
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'd3;
    #1 chk("f_gnt", {31'b0, if_gnt}, 32'd1);
    chk("f_ldgnt", {31'b0, ld_gnt}, 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    chk("f_busy1", {31'b0, busy}, 32'd1);
    chk("f_rv1", {31'b0, if_rvalid}, 32'd0);
    @(negedge clk);
    chk("f_busy2", {31'b0, busy}, 32'd1);
    chk("f_rv2", {31'b0, if_rvalid}, 32'd1);
    chk("f_rdata", if_rdata, 32'h2403000A);
    chk("f_ldrv2", {31'b0, ld_rvalid}, 32'd0);
    @(negedge clk);
    chk("f_rv3", {31'b0, if_rvalid}, 32'd0);
    chk("f_busy3", {31'b0, busy}, 32'd0);
    chk("f_hold", if_rdata, 32'h2403000A);

    // Tie: load wins (last grant was fetch in both builds), fetch granted at T+3
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'd5; ld_req = 1'b1; ld_addr = 8'd10;
    #1 chk("t_ldgnt", {31'b0, ld_gnt}, 32'd1);
    chk("t_ifgnt0", {31'b0, if_gnt}, 32'd0);
    @(negedge clk);
    ld_req = 1'b0;
    chk("t_ifgnt1", {31'b0, if_gnt}, 32'd0);
    @(negedge clk);
    chk("t_ldrv", {31'b0, ld_rvalid}, 32'd1);
    chk("t_ldrdata", {24'b0, ld_rdata}, 32'h0A);
    chk("t_ifrv", {31'b0, if_rvalid}, 32'd0);
    chk("t_ifgnt2", {31'b0, if_gnt}, 32'd0);
    @(negedge clk);
    chk("t_ifgnt3", {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    chk("t_ifrv5", {31'b0, if_rvalid}, 32'd1);
    chk("t_ifrdata", if_rdata, 32'h12345678);
    chk("t_ldhold", {24'b0, ld_rdata}, 32'h0A);

    // Two back-to-back ties with both requests held
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'd3; ld_req = 1'b1; ld_addr = 8'd2;
    #1 chk("t2_first_ld", {31'b0, ld_gnt}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
`ifdef ROUND_ROBIN_EN
    chk("t2_second_if", {31'b0, if_gnt}, 32'd1);
`else
    chk("t2_second_ld", {31'b0, ld_gnt}, 32'd1);
`endif
    @(negedge clk);
    if_req = 1'b0; ld_req = 1'b0;
    repeat (3) @(negedge clk);

    // Read-before-write on the same data address in the grant cycle
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 8'd2;
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 8'd2; wr_data = 32'h55;
    #1 chk("rbw_gnt", {31'b0, ld_gnt}, 32'd1);
    @(negedge clk);
    ld_req = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("rbw_rv", {31'b0, ld_rvalid}, 32'd1);
    chk("rbw_old", {24'b0, ld_rdata}, 32'h01);
    load("rbw_new", 8'd2, 8'h55);

    // Out of range fetch: zero data, normal timing, err from T+1
    chk("oor_err0", {31'b0, err}, 32'd0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'd20;
    #1 chk("oor_gnt", {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    chk("oor_err1", {31'b0, err}, 32'd1);
    @(negedge clk);
    chk("oor_rv", {31'b0, if_rvalid}, 32'd1);
    chk("oor_rdata", if_rdata, 32'd0);

    // Out of range write is dropped (must not alias onto dmem[0])
    wr(1'b1, 8'd16, 32'hEE);
    chk("oorw_err", {31'b0, err}, 32'd1);
    load("oorw_d0", 8'd0, 8'h77);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // Reset mid-request: grant at T, reset at T+1, nothing comes back
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'd3;
    #1 chk("rm_gnt", {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    rst_n = 1'b0;
    #1 chk_idle_zero("rm_in");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rm_rv2", {31'b0, if_rvalid}, 32'd0);
    @(negedge clk);
    chk("rm_rv3", {31'b0, if_rvalid}, 32'd0);
    chk("rm_busy3", {31'b0, busy}, 32'd0);
    fetch("rm_after", 8'd3, 32'h2403000A);
    load("rm_dmem", 8'd10, 8'h0A);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Response strobes must never overlap
  always @(negedge clk) begin
    if (rst_n && if_rvalid && ld_rvalid) begin
      total++;
      bad++;
      $error("FAIL rvalid_overlap: observed=both expected=one");
    end
  end

endmodule
